pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the five-stage core.
- Drives the active-low enable (en_n) and synchronous-clear (reset) inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Resolves load-use hazards, branch/jump redirects, data-memory wait states and multi-cycle MDU operations under one fixed priority.
- Exports a saturating stall counter for performance monitoring.

Parameters:
RESET_HOLD_CYCLES, 4, cycles the pipeline is held frozen and cleared after reset release (1..255)
MDU_TIMEOUT, 64, max MDU_WAIT cycles before forced release (1..1023)
CNT_W, 32, width of stall_cycles

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd index of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch/jump
ex_mdu_start  in  1  EX holds multi-cycle MDU op, start pulse
mdu_done  in  1  MDU result valid
mem_req  in  1  MEM stage issuing load/store
mem_ready  in  1  data memory accepts/completes access
pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n  out  1 each  stage enables, 0 = load
ifid_flush, idex_flush, exmem_flush  out  1 each  sync clear to stage register reset input
stall_cycles  out  CNT_W  cycles with pc_en_n=1 outside RESET_HOLD, saturating
ctrl_state  out  2  0 RESET_HOLD, 1 RUN, 2 MEM_WAIT, 3 MDU_WAIT
mdu_timeout  out  1  one-cycle pulse on MDU timeout

Behaviour:
- Registered elements: state, hold/timeout counter, stall_cycles, mdu_timeout. Enable/flush outputs are combinational from state plus inputs.
- reset_n=0 (async):
  - state=RESET_HOLD, counter=RESET_HOLD_CYCLES-1, stall_cycles=0, mdu_timeout=0.
  - Outputs: all en_n=1, all flush=1, ctrl_state=0.
- RESET_HOLD:
  - All en_n=1, all flush=1.
  - Counter decrements each cycle; at 0 go to RUN.
  - Exactly RESET_HOLD_CYCLES cycles after reset deassertion edge.
- RUN/release rules, in priority order (default: all en_n=0, flush=0):
  - P1 mem stall, mem_req & !mem_ready: all en_n=1, no flush; next MEM_WAIT.
  - P2 MDU, ex_mdu_start & !mdu_done:
    - pc/ifid/idex en_n=1; exmem_en_n=0 with exmem_flush=1 (bubble); memwb_en_n=0.
    - Next MDU_WAIT; timeout counter=0.
    - ex_mdu_start & mdu_done in the same cycle: no stall, continue to P3.
  - P3 redirect, ex_redirect: all en_n=0, ifid_flush=1, idex_flush=1. Overrides P4, since the ID instruction is wrong-path.
  - P4 load-use:
    - Condition: ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
    - Response: pc_en_n=1, ifid_en_n=1, idex_en_n=0 with idex_flush=1; exmem/memwb enabled.
    - Lasts exactly 1 cycle: the load advances out of EX.
- MEM_WAIT:
  - While !mem_ready: all en_n=1, no flush.
  - On mem_ready: apply P2–P4 this same cycle (P1 ignored); next state per P2, else RUN.
- MDU_WAIT:
  - Holds P2 outputs; counter increments.
  - On mdu_done: apply P3–P4 with EX enabled; next RUN.
  - Counter reaching MDU_TIMEOUT-1 without done: same release as done, mdu_timeout=1 for that cycle, next RUN.
  - A mem stall (P1) during MDU_WAIT overrides: all en_n=1, stay MDU_WAIT. The counter keeps counting.
- Simultaneous events are resolved only by the P1>P2>P3>P4 order. A stalled redirect stays asserted by the frozen EX register and takes effect on release.
- stall_cycles:
  - +1 on each cycle with pc_en_n=1 and state!=RESET_HOLD.
  - Holds at all-ones.
- Reset mid-operation (any state): immediate async return to the reset values above.

Test Plan:
- Reset_n low 3 cycles, release: all flush=1 and en_n=1 for exactly 4 cycles; ctrl_state 0→1 on cycle 5; stall_cycles=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle pc_en_n=ifid_en_n=1, idex_flush=1; next cycle (ex_mem_read=0) all enabled; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- Redirect plus load-use hazard in the same cycle → ifid_flush=idex_flush=1, pc_en_n=0, no stall.
- mem_req=1, mem_ready=0 for 3 cycles with ex_redirect=1 → all frozen 3 cycles, ctrl_state=2. Then mem_ready=1 → redirect flush applied that cycle, state RUN; stall_cycles+=3.
- ex_mdu_start, mdu_done after 5 cycles → front stalled, exmem_flush=1 each cycle, release on done. Second op with no done → mdu_timeout pulse at cycle 64, return to RUN.
- Assert reset_n=0 mid MDU_WAIT, asynchronously between clock edges → outputs return to reset values before the next edge; stall_cycles=0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline and enable/flush/status outputs of pipeline_ctrl.
// The master side is the datapath; the slave side is the controller.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             ex_mdu_start;
    logic             mdu_done;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en_n;
    logic             ifid_en_n;
    logic             idex_en_n;
    logic             exmem_en_n;
    logic             memwb_en_n;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       ctrl_state;
    logic             mdu_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_redirect,
               ex_mdu_start, mdu_done, mem_req, mem_ready,
        input  pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n, ifid_flush, idex_flush,
               exmem_flush, stall_cycles, ctrl_state, mdu_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read, ex_redirect,
               ex_mdu_start, mdu_done, mem_req, mem_ready,
        output pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n, ifid_flush, idex_flush,
               exmem_flush, stall_cycles, ctrl_state, mdu_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage core: load-use, redirect, memory wait and MDU
// wait handling under a fixed priority, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter int unsigned MDU_TIMEOUT       = 64,
    parameter int unsigned CNT_W             = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    pipeline_ctrl_if.slave bus
);

    localparam int unsigned TmrW = 10;

    typedef enum logic [1:0] {
        StResetHold = 2'd0,
        StRun       = 2'd1,
        StMemWait   = 2'd2,
        StMduWait   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             timeout_q, timeout_d;

    logic mem_stall, mdu_stall, load_use, mdu_expired, mdu_release;
    logic act_hold, act_freeze, act_bubble, act_resolve;
    logic pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n;
    logic ifid_flush, idex_flush, exmem_flush;

    assign mem_stall   = bus.mem_req & ~bus.mem_ready;
    assign mdu_stall   = bus.ex_mdu_start & ~bus.mdu_done;
    assign load_use    = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                         ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                          (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
    assign mdu_expired = (tmr_q == TmrW'(MDU_TIMEOUT - 1));
    assign mdu_release = bus.mdu_done | mdu_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StResetHold;
            tmr_q     <= TmrW'(RESET_HOLD_CYCLES - 1);
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StResetHold: begin
                if (tmr_q == '0) begin
                    state_d = StRun;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StRun: begin
                if (mem_stall) begin
                    state_d = StMemWait;
                end else if (mdu_stall) begin
                    state_d = StMduWait;
                    tmr_d   = '0;
                end
            end
            StMemWait: begin
                if (bus.mem_ready) begin
                    if (mdu_stall) begin
                        state_d = StMduWait;
                        tmr_d   = '0;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StMduWait: begin
                // A memory stall defers release; the timer parks at its limit meanwhile.
                if (mem_stall) begin
                    if (!mdu_expired) begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else if (mdu_release) begin
                    state_d   = StRun;
                    timeout_d = mdu_expired & ~bus.mdu_done;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StResetHold;
        endcase
    end

    // Classify the cycle: hold (reset), freeze, MDU bubble, or redirect/load-use resolution.
    always_comb begin
        act_hold    = 1'b0;
        act_freeze  = 1'b0;
        act_bubble  = 1'b0;
        act_resolve = 1'b0;
        unique case (state_q)
            StResetHold: act_hold = 1'b1;
            StRun: begin
                if (mem_stall) begin
                    act_freeze = 1'b1;
                end else if (mdu_stall) begin
                    act_bubble = 1'b1;
                end else begin
                    act_resolve = 1'b1;
                end
            end
            StMemWait: begin
                if (!bus.mem_ready) begin
                    act_freeze = 1'b1;
                end else if (mdu_stall) begin
                    act_bubble = 1'b1;
                end else begin
                    act_resolve = 1'b1;
                end
            end
            StMduWait: begin
                if (mem_stall) begin
                    act_freeze = 1'b1;
                end else if (mdu_release) begin
                    act_resolve = 1'b1;
                end else begin
                    act_bubble = 1'b1;
                end
            end
            default: act_hold = 1'b1;
        endcase
    end

    always_comb begin
        pc_en_n     = 1'b0;
        ifid_en_n   = 1'b0;
        idex_en_n   = 1'b0;
        exmem_en_n  = 1'b0;
        memwb_en_n  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (act_hold || act_freeze) begin
            pc_en_n    = 1'b1;
            ifid_en_n  = 1'b1;
            idex_en_n  = 1'b1;
            exmem_en_n = 1'b1;
            memwb_en_n = 1'b1;
        end
        if (act_hold) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end
        if (act_bubble) begin
            pc_en_n     = 1'b1;
            ifid_en_n   = 1'b1;
            idex_en_n   = 1'b1;
            exmem_flush = 1'b1;
        end
        if (act_resolve) begin
            // The ID instruction is wrong-path on a redirect, so its hazard is moot.
            if (bus.ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en_n    = 1'b1;
                ifid_en_n  = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((state_q != StResetHold) && pc_en_n && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    assign bus.pc_en_n      = pc_en_n;
    assign bus.ifid_en_n    = ifid_en_n;
    assign bus.idex_en_n    = idex_en_n;
    assign bus.exmem_en_n   = exmem_en_n;
    assign bus.memwb_en_n   = memwb_en_n;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_flush  = exmem_flush;
    assign bus.stall_cycles = stall_q;
    assign bus.ctrl_state   = state_q;
    assign bus.mdu_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each vector queues its expected outputs, and a
// negedge monitor pops and compares them.
module tb_pipeline_ctrl;

    localparam int unsigned CntW = 7;

    localparam logic [7:0] FU1 = 8'h80, FU2 = 8'h40, FMR = 8'h20, FRD = 8'h10;
    localparam logic [7:0] FMS = 8'h08, FMD = 8'h04, FRQ = 8'h02, FRY = 8'h01;

    // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem}
    localparam logic [4:0] EnRun = 5'b00000, EnFrz = 5'b11111;
    localparam logic [4:0] EnLu = 5'b11000, EnMdu = 5'b11100;
    localparam logic [2:0] FlNone = 3'b000, FlAll = 3'b111, FlRd = 3'b110;
    localparam logic [2:0] FlLu = 3'b010, FlMdu = 3'b001;

    typedef struct packed {
        logic [15:0]     id;
        logic [4:0]      en;
        logic [2:0]      fl;
        logic [1:0]      st;
        logic [CntW-1:0] sc;
        logic            to;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CntW)) bus ();

    pipeline_ctrl #(
        .RESET_HOLD_CYCLES(4),
        .MDU_TIMEOUT      (64),
        .CNT_W            (CntW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   vec_id = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL vec%0d %s got=%0h want=%0h", id, nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("en_n", int'(mon_e.id),
                32'({bus.pc_en_n, bus.ifid_en_n, bus.idex_en_n, bus.exmem_en_n,
                     bus.memwb_en_n}), 32'(mon_e.en));
            chk("flush", int'(mon_e.id),
                32'({bus.ifid_flush, bus.idex_flush, bus.exmem_flush}), 32'(mon_e.fl));
            chk("ctrl_state", int'(mon_e.id), 32'(bus.ctrl_state), 32'(mon_e.st));
            chk("stall_cycles", int'(mon_e.id), 32'(bus.stall_cycles), 32'(mon_e.sc));
            chk("mdu_timeout", int'(mon_e.id), 32'(bus.mdu_timeout), 32'(mon_e.to));
        end
    end

    task automatic cyc(input logic [7:0] f, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [4:0] en, input logic [2:0] fl,
                       input logic [1:0] st, input int sc, input logic to);
        exp_t e;
        bus.id_uses_rs1  = f[7];
        bus.id_uses_rs2  = f[6];
        bus.ex_mem_read  = f[5];
        bus.ex_redirect  = f[4];
        bus.ex_mdu_start = f[3];
        bus.mdu_done     = f[2];
        bus.mem_req      = f[1];
        bus.mem_ready    = f[0];
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.ex_rd        = rd;
        e.id = 16'(vec_id);
        e.en = en;
        e.fl = fl;
        e.st = st;
        e.sc = CntW'(sc);
        e.to = to;
        exp_q.push_back(e);
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 127) ? 127 : v;
    endfunction

    initial begin
        cyc_init();
        @(posedge clk);
        #1;
        // Held in reset, then exactly four hold cycles after release.
        repeat (3) cyc(8'h00, 0, 0, 0, EnFrz, FlAll, 2'd0, 0, 1'b0);
        reset_n = 1'b1;
        repeat (4) cyc(8'h00, 0, 0, 0, EnFrz, FlAll, 2'd0, 0, 1'b0);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 0, 1'b0);

        // Load-use via rs2 and rs1, then non-hazard variants.
        cyc(FU2 | FMR, 0, 5, 5, EnLu, FlLu, 2'd1, 0, 1'b0);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 1, 1'b0);
        cyc(FU1 | FMR, 7, 0, 7, EnLu, FlLu, 2'd1, 1, 1'b0);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 2, 1'b0);
        cyc(FU2 | FMR, 0, 0, 0, EnRun, FlNone, 2'd1, 2, 1'b0);
        cyc(FU1 | FU2 | FMR, 3, 9, 4, EnRun, FlNone, 2'd1, 2, 1'b0);
        cyc(FMR, 6, 6, 6, EnRun, FlNone, 2'd1, 2, 1'b0);
        cyc(FU1, 6, 0, 6, EnRun, FlNone, 2'd1, 2, 1'b0);

        // Redirect beats load-use.
        cyc(FU2 | FMR | FRD, 0, 5, 5, EnRun, FlRd, 2'd1, 2, 1'b0);

        // Memory stall holding a redirect, released into the redirect flush.
        cyc(FRQ | FRD, 0, 0, 0, EnFrz, FlNone, 2'd1, 2, 1'b0);
        cyc(FRQ | FRD, 0, 0, 0, EnFrz, FlNone, 2'd2, 3, 1'b0);
        cyc(FRQ | FRD, 0, 0, 0, EnFrz, FlNone, 2'd2, 4, 1'b0);
        cyc(FRQ | FRY | FRD, 0, 0, 0, EnRun, FlRd, 2'd2, 5, 1'b0);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 5, 1'b0);

        // Memory stall released into a load-use bubble.
        cyc(FRQ, 0, 0, 0, EnFrz, FlNone, 2'd1, 5, 1'b0);
        cyc(FRY | FU1 | FMR, 2, 0, 2, EnLu, FlLu, 2'd2, 6, 1'b0);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 7, 1'b0);

        // MDU finishing in its start cycle does not stall.
        cyc(FMS | FMD, 0, 0, 0, EnRun, FlNone, 2'd1, 7, 1'b0);

        // MDU op done after five stalled cycles, with a memory stall in the middle.
        cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd1, 7, 1'b0);
        cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd3, 8, 1'b0);
        cyc(FMS | FRQ, 0, 0, 0, EnFrz, FlNone, 2'd3, 9, 1'b0);
        cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd3, 10, 1'b0);
        cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd3, 11, 1'b0);
        cyc(FMS | FMD | FRD, 0, 0, 0, EnRun, FlRd, 2'd3, 12, 1'b0);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 12, 1'b0);

        // MDU op that never completes: released on the 64th wait cycle.
        cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd1, 12, 1'b0);
        for (int i = 0; i < 63; i++) begin
            cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd3, 13 + i, 1'b0);
        end
        cyc(FMS, 0, 0, 0, EnRun, FlNone, 2'd3, 76, 1'b0);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 76, 1'b1);
        cyc(8'h00, 0, 0, 0, EnRun, FlNone, 2'd1, 76, 1'b0);

        // Counter saturates, then reset lands mid-MDU wait between clock edges.
        cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd1, 76, 1'b0);
        for (int i = 0; i < 60; i++) begin
            cyc(FMS, 0, 0, 0, EnMdu, FlMdu, 2'd3, sat(77 + i), 1'b0);
        end
        reset_n = 1'b0;
        cyc(FMS, 0, 0, 0, EnFrz, FlAll, 2'd0, 0, 1'b0);
        cyc(8'h00, 0, 0, 0, EnFrz, FlAll, 2'd0, 0, 1'b0);
        reset_n = 1'b1;
        repeat (4) cyc(8'h00, 0, 0, 0, EnFrz, FlAll, 2'd0, 0, 1'b0);
        cyc(FRD, 0, 0, 0, EnRun, FlRd, 2'd1, 0, 1'b0);

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic cyc_init();
        bus.id_uses_rs1  = 1'b0;
        bus.id_uses_rs2  = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_redirect  = 1'b0;
        bus.ex_mdu_start = 1'b0;
        bus.mdu_done     = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.ex_rd        = '0;
    endtask

endmodule
